// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle between the Z80 I/O decode and the UART transmitter.
// Latency: none; this is wiring only.
// Backpressure: the master polls full_o before asserting wr_i; overflow_o flags any dropped write.
interface uart_tx_fifo_if;
   logic [7:0] data_i;
   logic       wr_i;
   logic       full_o;
   logic       empty_o;
   logic       busy_o;
   logic       overflow_o;

   // CPU side: drives bytes and strobes, reads status
   modport master (
      output data_i, wr_i,
      input  full_o, empty_o, busy_o, overflow_o
   );

   // Transmitter side: accepts bytes, reports status
   modport slave (
      input  data_i, wr_i,
      output full_o, empty_o, busy_o, overflow_o
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined) with a small TX FIFO.
// Latency: write at cycle 0 -> empty_o low at cycle 1 -> start bit on uart_tx_o at cycle 2.
// Backpressure: writes while full_o=1 are dropped and set the sticky overflow_o until reset.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 27000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   uart_tx_fifo_if.slave bus,
   output logic          uart_tx_o
);
   localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int BW  = $clog2(DIV);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   logic [7:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_full;
   logic          r_empty;
   logic          r_busy;
   logic          r_ovf;

   state_t        r_state;
   logic [BW-1:0] r_baud;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_tx;
`ifdef UART_TX_PARITY_EN
   logic          r_par;
`endif

   logic          w_bit_end;
   logic          w_push;
   logic          w_pop;
   logic          w_idle_nxt;
   logic [7:0]    w_head;
   logic [AW:0]   w_count_nxt;

   assign w_bit_end   = (r_baud == BW'(DIV - 1));
   // Acceptance uses the registered full flag; a pop in the same cycle does not free a slot.
   assign w_push      = bus.wr_i & ~r_full;
   assign w_pop       = ~r_empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
   assign w_idle_nxt  = ~w_pop & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_end));
   assign w_head      = r_mem[r_rd_ptr];
   assign w_count_nxt = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);

   assign bus.full_o     = r_full;
   assign bus.empty_o    = r_empty;
   assign bus.busy_o     = r_busy;
   assign bus.overflow_o = r_ovf;
   assign uart_tx_o      = r_tx;

   // FIFO storage: not reset, contents are only meaningful below the count
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wr_ptr] <= bus.data_i;
   end

   // FIFO pointers, occupancy and registered status flags
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_busy   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == (AW + 1)'(FIFO_DEPTH));
         r_empty <= (w_count_nxt == '0);
         r_busy  <= ~w_idle_nxt | (w_count_nxt != '0);
         r_ovf   <= r_ovf | (bus.wr_i & r_full);
      end
   end

   // Serializer: baud counter restarts at every bit so each frame is aligned to its start bit
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_tx    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_baud <= '0;
               if (w_pop) begin
                  r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                  r_par   <= ^w_head;
`endif
                  r_tx    <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_bit   <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_tx    <= r_par;
                     r_state <= S_PARITY;
`else
                     r_tx    <= 1'b1;
                     r_state <= S_STOP;
`endif
                  end else begin
                     r_bit   <= r_bit + 3'd1;
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
`endif
            S_STOP: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  // Chain straight into the next start bit when more data is queued
                  if (w_pop) begin
                     r_shift <= w_head;
`ifdef UART_TX_PARITY_EN
                     r_par   <= ^w_head;
`endif
                     r_tx    <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_tx    <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            default: begin
               r_tx    <= 1'b1;
               r_baud  <= '0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DIV=10, FIFO_DEPTH=4.
// A line monitor decodes frames and pops the expected-byte scoreboard.
// Scenario tasks run in sequence and check timing and status inline.
module tb_uart_tx_fifo;
   localparam int CLK_FREQ = 1000000;
   localparam int BAUD     = 100000;
   localparam int DEPTH    = 4;
   localparam int DIV      = 10;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS    = 11;
`else
   localparam int NBITS    = 10;
`endif
   localparam int FRAME    = NBITS * DIV;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   logic uart_tx_o;

   uart_tx_fifo_if bus();

   uart_tx_fifo #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD       (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .bus       (bus),
      .uart_tx_o (uart_tx_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc++;

   int n_tests = 0;
   int n_fail  = 0;
   int n_frames = 0;
   bit mon_busy = 1'b0;
   logic [7:0] exp_q[$];
   int start_q[$];

   // Line monitor: detect a start bit, sample each bit at its middle, compare against scoreboard
   initial begin : monitor
      logic        prev;
      logic [10:0] fb;
      logic [7:0]  d;
      logic [7:0]  e;
      bit          ab;
      int          st;
      prev = 1'b1;
      forever begin
         @(negedge clk_i);
         if (rst_i && prev && uart_tx_o === 1'b0) begin
            mon_busy = 1'b1;
            st = cyc;
            ab = 1'b0;
            fb = '1;
            for (int k = 0; k < NBITS; k++) begin
               repeat ((k == 0) ? DIV / 2 : DIV) begin
                  @(negedge clk_i);
                  if (!rst_i) ab = 1'b1;
               end
               fb[k] = uart_tx_o;
            end
            if (!ab) begin
               d = fb[8:1];
               n_frames++;
               start_q.push_back(st);
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL mon_unexpected_frame got=%02h expected=none", d);
               end else begin
                  e = exp_q.pop_front();
                  if (d !== e) begin
                     n_fail++;
                     $display("FAIL mon_data got=%02h expected=%02h", d, e);
                  end
               end
               n_tests++;
               if (fb[NBITS-1] !== 1'b1) begin
                  n_fail++;
                  $display("FAIL mon_stop_bit got=%b expected=1", fb[NBITS-1]);
               end
`ifdef UART_TX_PARITY_EN
               n_tests++;
               if (fb[9] !== ^d) begin
                  n_fail++;
                  $display("FAIL mon_parity got=%b expected=%b", fb[9], ^d);
               end
`endif
            end
            prev = uart_tx_o;
            mon_busy = 1'b0;
         end else begin
            prev = rst_i ? uart_tx_o : 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic goto_cyc(input int t);
      int g = 0;
      while (cyc < t && g < 100000) begin
         step();
         g++;
      end
   endtask

   task automatic drain(input string name, input int bound);
      int k = 0;
      while ((exp_q.size() != 0 || mon_busy) && k < bound) begin
         step();
         k++;
      end
      n_tests++;
      if (exp_q.size() != 0 || mon_busy) begin
         n_fail++;
         $display("FAIL %s_drain_timeout pending=%0d expected=0 within %0d cycles", name, exp_q.size(), bound);
      end
      repeat (DIV) step();
   endtask

   task automatic test_reset();
      logic [4:0] got;
      for (int i = 0; i < 200; i++) begin
         got = {uart_tx_o, bus.empty_o, bus.busy_o, bus.full_o, bus.overflow_o};
         n_tests++;
         if (got !== 5'b11000) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d tx/empty/busy/full/ovf=%b expected=11000", i, got);
         end
         step();
      end
   endtask

   task automatic test_single(input logic [7:0] d);
      int t0;
      logic [10:0] fb;
      fb = '1;
      fb[0] = 1'b0;
      fb[8:1] = d;
`ifdef UART_TX_PARITY_EN
      fb[9] = ^d;
`endif
      bus.data_i = d;
      bus.wr_i = 1'b1;
      exp_q.push_back(d);
      t0 = cyc;
      step();
      bus.wr_i = 1'b0;
      n_tests++;
      if ({uart_tx_o, bus.empty_o, bus.busy_o} !== 3'b101) begin
         n_fail++;
         $display("FAIL single_cycle1 tx/empty/busy=%b expected=101", {uart_tx_o, bus.empty_o, bus.busy_o});
      end
      step();
      n_tests++;
      if (uart_tx_o !== 1'b0) begin
         n_fail++;
         $display("FAIL single_start_edge tx=%b expected=0 at cycle 2", uart_tx_o);
      end
      for (int k = 0; k < NBITS; k++) begin
         goto_cyc(t0 + 2 + k * DIV + DIV / 2);
         n_tests++;
         if (uart_tx_o !== fb[k]) begin
            n_fail++;
            $display("FAIL single_bit%0d tx=%b expected=%b", k, uart_tx_o, fb[k]);
         end
      end
      goto_cyc(t0 + 2 + FRAME - 1);
      n_tests++;
      if ({uart_tx_o, bus.busy_o} !== 2'b11) begin
         n_fail++;
         $display("FAIL single_last_stop tx/busy=%b expected=11", {uart_tx_o, bus.busy_o});
      end
      goto_cyc(t0 + 2 + FRAME + 1);
      n_tests++;
      if ({uart_tx_o, bus.busy_o, bus.empty_o} !== 3'b101) begin
         n_fail++;
         $display("FAIL single_idle tx/busy/empty=%b expected=101", {uart_tx_o, bus.busy_o, bus.empty_o});
      end
      drain("single", 3 * FRAME);
   endtask

   task automatic test_back_to_back();
      logic [7:0] bytes [3];
      int t0;
      int s;
      bytes[0] = 8'hA5;
      bytes[1] = 8'h3C;
      bytes[2] = 8'hFF;
      start_q.delete();
      t0 = cyc;
      for (int i = 0; i < 3; i++) begin
         bus.data_i = bytes[i];
         bus.wr_i = 1'b1;
         exp_q.push_back(bytes[i]);
         step();
      end
      bus.wr_i = 1'b0;
      drain("b2b", 4 * FRAME);
      n_tests++;
      if (start_q.size() != 3) begin
         n_fail++;
         $display("FAIL b2b_frame_count got=%0d expected=3", start_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            s = start_q[i];
            n_tests++;
            if (s - t0 != 2 + i * FRAME) begin
               n_fail++;
               $display("FAIL b2b_start%0d offset=%0d expected=%0d", i, s - t0, 2 + i * FRAME);
            end
         end
      end
   endtask

   task automatic test_overflow();
      int n0;
      n0 = n_frames;
      for (int i = 0; i < 6; i++) begin
         bus.data_i = 8'h11 + 8'(i);
         bus.wr_i = 1'b1;
         if (i < 5) exp_q.push_back(8'h11 + 8'(i));
         if (i == 4) begin
            n_tests++;
            if (bus.full_o !== 1'b0) begin
               n_fail++;
               $display("FAIL ovf_full_before got=%b expected=0", bus.full_o);
            end
         end
         if (i == 5) begin
            n_tests++;
            if ({bus.full_o, bus.overflow_o} !== 2'b10) begin
               n_fail++;
               $display("FAIL ovf_full_at_6th full/ovf=%b expected=10", {bus.full_o, bus.overflow_o});
            end
         end
         step();
      end
      bus.wr_i = 1'b0;
      n_tests++;
      if (bus.overflow_o !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set got=%b expected=1", bus.overflow_o);
      end
      drain("ovf", 7 * FRAME);
      n_tests++;
      if (n_frames - n0 != 5) begin
         n_fail++;
         $display("FAIL ovf_frames got=%0d expected=5", n_frames - n0);
      end
      n_tests++;
      if ({bus.overflow_o, bus.empty_o, bus.busy_o} !== 3'b110) begin
         n_fail++;
         $display("FAIL ovf_sticky ovf/empty/busy=%b expected=110", {bus.overflow_o, bus.empty_o, bus.busy_o});
      end
   endtask

   task automatic test_midreset();
      int t0;
      int n0;
      t0 = cyc;
      bus.data_i = 8'h00; bus.wr_i = 1'b1; exp_q.push_back(8'h00); step();
      bus.data_i = 8'hAA; exp_q.push_back(8'hAA); step();
      bus.data_i = 8'hBB; exp_q.push_back(8'hBB); step();
      bus.wr_i = 1'b0;
      goto_cyc(t0 + 2 + 35);
      n_tests++;
      if (uart_tx_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_frame_line tx=%b expected=0", uart_tx_o);
      end
      #2;
      rst_i = 1'b0;
      #1;
      n_tests++;
      if ({uart_tx_o, bus.empty_o, bus.busy_o, bus.full_o, bus.overflow_o} !== 5'b11000) begin
         n_fail++;
         $display("FAIL rst_async tx/empty/busy/full/ovf=%b expected=11000",
                  {uart_tx_o, bus.empty_o, bus.busy_o, bus.full_o, bus.overflow_o});
      end
      exp_q.delete();
      n0 = n_frames;
      repeat (3) step();
      rst_i = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step();
         n_tests++;
         if ({uart_tx_o, bus.empty_o} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_after_release cyc=%0d tx/empty=%b expected=11", i, {uart_tx_o, bus.empty_o});
         end
      end
      n_tests++;
      if (n_frames != n0) begin
         n_fail++;
         $display("FAIL rst_no_frames got=%0d expected=0", n_frames - n0);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity(input logic [7:0] d, input logic pbit);
      int t0;
      bus.data_i = d;
      bus.wr_i = 1'b1;
      exp_q.push_back(d);
      t0 = cyc;
      step();
      bus.wr_i = 1'b0;
      goto_cyc(t0 + 2 + 9 * DIV + DIV / 2);
      n_tests++;
      if (uart_tx_o !== pbit) begin
         n_fail++;
         $display("FAIL parity_bit_%02h got=%b expected=%b", d, uart_tx_o, pbit);
      end
      goto_cyc(t0 + 2 + FRAME - 1);
      n_tests++;
      if (bus.busy_o !== 1'b1) begin
         n_fail++;
         $display("FAIL parity_len_busy_%02h got=%b expected=1", d, bus.busy_o);
      end
      goto_cyc(t0 + 2 + FRAME + 1);
      n_tests++;
      if ({uart_tx_o, bus.busy_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL parity_len_idle_%02h tx/busy=%b expected=10", d, {uart_tx_o, bus.busy_o});
      end
      drain("parity", 3 * FRAME);
   endtask
`endif

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin : main
      bus.data_i = 8'h00;
      bus.wr_i = 1'b0;
      rst_i = 1'b0;
      repeat (3) step();
      rst_i = 1'b1;
      step();
      test_reset();
      test_single(8'h55);
      test_back_to_back();
      test_overflow();
      test_midreset();
`ifdef UART_TX_PARITY_EN
      test_parity(8'h07, 1'b1);
      test_parity(8'h03, 1'b0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
